// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. MUL/DIV results.
// Optional WB_ARB_PERF_EN adds stall-cycle and forced-grant performance counters.
module wb_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            pipe_valid_i,
  output logic            pipe_ready_o,
  input  logic [4:0]      pipe_rd_addr_i,
  input  logic [XLEN-1:0] pipe_rd_data_i,
  input  logic            md_valid_i,
  output logic            md_ready_o,
  input  logic [4:0]      md_rd_addr_i,
  input  logic [XLEN-1:0] md_rd_data_i,
  output logic            stall_o,
`ifdef WB_ARB_PERF_EN
  output logic [31:0]     perf_stall_cnt_o,
  output logic [15:0]     perf_force_cnt_o,
`endif
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o
);

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  typedef enum logic {S_NORM, S_MD_FORCE} state_e;

  state_e            state_q, state_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              pipe_ready, md_ready, stall;
  logic              xfer_pipe, xfer_md;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pipe_ready = 1'b0;
    md_ready   = 1'b0;
    stall      = 1'b0;
    if (!reset && !stall_i) begin
      case (state_q)
        S_NORM: begin
          if (pipe_valid_i) begin
            pipe_ready = 1'b1;
            if (md_valid_i) begin
              if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WCW'(1);
              if (wait_cnt_q == WAIT_LAST) state_d = S_MD_FORCE;
            end
          end else begin
            md_ready   = md_valid_i;
            wait_cnt_d = '0;
          end
        end
        S_MD_FORCE: begin
          // Leaves the force state whether or not md_valid_i is still up.
          md_ready   = 1'b1;
          stall      = pipe_valid_i;
          state_d    = S_NORM;
          wait_cnt_d = '0;
        end
        default: state_d = S_NORM;
      endcase
    end
  end

  assign xfer_pipe = pipe_ready & pipe_valid_i;
  assign xfer_md   = md_ready & md_valid_i;

  always_comb begin
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_we_d    = 1'b0;
    if (xfer_pipe && pipe_rd_addr_i != 5'd0) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd_addr_i;
      rf_wdata_d = pipe_rd_data_i;
    end else if (xfer_md && md_rd_addr_i != 5'd0) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = md_rd_addr_i;
      rf_wdata_d = md_rd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_NORM;
      wait_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_stall_cnt_q;
  logic [15:0] perf_force_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt_q <= '0;
      perf_force_cnt_q <= '0;
    end else begin
      if (stall && perf_stall_cnt_q != 32'hFFFF_FFFF) perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
      if (state_q == S_MD_FORCE && xfer_md) perf_force_cnt_q <= perf_force_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_cnt_q;
  assign perf_force_cnt_o = perf_force_cnt_q;
`endif

  assign pipe_ready_o = pipe_ready;
  assign md_ready_o   = md_ready;
  assign stall_o      = stall;
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters: the in-order pipeline write-back stage and the multi-cycle MUL/DIV unit (M extension).
- The pipeline has priority by default. A starvation counter forces a MUL/DIV grant after a bounded wait, and the arbiter stalls the pipeline while that happens.
- Sits between the write-back stage / MUL/DIV result interface and the register file. It is the only driver of the write port.

Parameters:
- MAX_WAIT, 4: maximum number of cycles a valid MUL/DIV result may lose arbitration before it is forced. Legal range 1..255.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  global stall from the control unit; freezes arbitration
- pipe_valid_i  in  1  pipeline write request
- pipe_ready_o  out  1  pipeline request accepted this cycle
- pipe_rd_addr_i  in  5  pipeline destination register
- pipe_rd_data_i  in  XLEN  pipeline write data
- md_valid_i  in  1  MUL/DIV result valid
- md_ready_o  out  1  MUL/DIV result accepted this cycle
- md_rd_addr_i  in  5  MUL/DIV destination register
- md_rd_data_i  in  XLEN  MUL/DIV result
- stall_o  out  1  arbiter-induced pipeline stall request
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  5  register-file write address (registered)
- rf_wdata_o  out  XLEN  register-file write data (registered)

Behaviour:
- Reset values:
  - Outputs: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - Internal: state=S_NORM, wait_cnt=0.
  - Combinational outputs evaluate to 0 while reset=1.
- Handshakes:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - pipe_ready_o, md_ready_o and stall_o are combinational from state, wait_cnt, the valid inputs and stall_i.
  - At most one of pipe_ready_o and md_ready_o is high in any cycle.
- stall_i=1: both readies are 0 and stall_o=0. No write is issued (rf_we_o=0 next cycle). state and wait_cnt hold.
- S_NORM:
  - pipe_valid_i=1: grant pipe (pipe_ready_o=1).
    - If md_valid_i is also 1: wait_cnt++.
    - If wait_cnt was MAX_WAIT-1 before the increment, next state is S_MD_FORCE.
  - pipe_valid_i=0 and md_valid_i=1: grant md (md_ready_o=1); wait_cnt<=0.
  - Neither valid: no grant; wait_cnt<=0.
- S_MD_FORCE:
  - md_ready_o=1, pipe_ready_o=0, stall_o=pipe_valid_i.
  - On transfer: wait_cnt<=0, next state S_NORM.
  - If md_valid_i drops (illegal protocol): return to S_NORM with wait_cnt<=0 and no write.
- Write port:
  - A grant accepted at edge N produces rf_we_o=1 after edge N, with the winner's address and data. Latency is 1 cycle.
  - No grant: rf_we_o=0. rf_waddr_o and rf_wdata_o hold their last values.
- x0:
  - A request with rd_addr=0 completes its handshake, but rf_we_o stays 0 and the address/data registers do not update.
  - An x0 request still counts as a grant for arbitration and wait_cnt.
- Same rd on both requesters in one cycle: the winner writes first and the loser writes in a later cycle. Ordering hazards are handled by the issue logic, not here.
- wait_cnt width is $clog2(MAX_WAIT+1). It saturates at MAX_WAIT and never wraps.
- Reset mid-operation: a pending force is discarded. Any write registered in that cycle is suppressed (rf_we_o=0 after the reset edge).

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt_o (32 bit): counts cycles with stall_o=1. Resets to 0 and saturates at 0xFFFFFFFF.
  - Adds output perf_force_cnt_o (16 bit): counts S_MD_FORCE transfers. Resets to 0 and wraps on overflow.
- Undefined: neither port nor counter exists. Functional behaviour is identical.

Test Plan:
- Only pipe_valid, rd=5, data=0xDEADBEEF at cycle 0 -> pipe_ready_o=1 at cycle 0; cycle 1 rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF.
- Only md_valid, rd=7, data=0x12345678 -> md_ready_o=1 same cycle; next cycle rf_we_o=1, rf_waddr_o=7.
- MAX_WAIT=4; pipe_valid and md_valid held high continuously -> pipe granted 4 cycles; 5th cycle md_ready_o=1, pipe_ready_o=0, stall_o=1; pipe granted again on the 6th cycle.
- pipe request rd=0, data=0xFFFFFFFF -> pipe_ready_o=1; next cycle rf_we_o=0 and rf_waddr_o/rf_wdata_o unchanged.
- Both valid with stall_i=1 for 3 cycles -> no readies, rf_we_o=0, wait_cnt unchanged; after release, arbitration resumes from the prior wait_cnt.
- Reset asserted while in S_MD_FORCE -> next cycle state=S_NORM, rf_we_o=0, all readies 0 while reset high; with WB_ARB_PERF_EN, both counters read 0.
